// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, synchronous program-memory reads, 2-entry return queue, jump redirect and HALT.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int INST_WIDTH = 16,
  parameter int OPCODE_MSB = 15,
  parameter int OPCODE_LSB = 11,
  parameter logic [OPCODE_MSB-OPCODE_LSB:0] HALT_OPCODE = 5'h1F
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [INST_WIDTH-1:0] mem_data,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  jump,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic                  halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           fetched_count,
  output logic [31:0]           stall_count
`endif
);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] flight_pc;
  logic                  inflight;
  logic                  halt_seen;
  logic [1:0]            count;
  logic [INST_WIDTH-1:0] q0_data;
  logic [INST_WIDTH-1:0] q1_data;
  logic [ADDR_WIDTH-1:0] q0_pc;
  logic [ADDR_WIDTH-1:0] q1_pc;

  logic       pop;
  logic       push;
  logic       incoming_halt;
  logic [1:0] eff_occ;

  // Occupancy after this cycle's pop counts as free space, so a pop and an
  // issue can overlap and sustain one instruction per cycle.
  always_comb begin
    inst_valid    = (count != 2'd0) && !halted;
    inst          = q0_data;
    inst_pc       = q0_pc;
    pop           = inst_valid && inst_ready;
    push          = inflight;
    incoming_halt = inflight && (mem_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);
    eff_occ       = count - {1'b0, pop};
    mem_read_en   = reset && !halt_seen && !halted && !jump && !incoming_halt &&
                    ((eff_occ + {1'b0, inflight}) < 2'd2);
    mem_addr      = mem_read_en ? pc : '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc        <= '0;
      flight_pc <= '0;
      inflight  <= 1'b0;
      halt_seen <= 1'b0;
      halted    <= 1'b0;
      count     <= 2'd0;
      q0_data   <= '0;
      q1_data   <= '0;
      q0_pc     <= '0;
      q1_pc     <= '0;
    end else if (jump && !halted) begin
      pc        <= jump_target;
      count     <= 2'd0;
      inflight  <= 1'b0;
      halt_seen <= 1'b0;
    end else begin
      if (pop) begin
        q0_data <= q1_data;
        q0_pc   <= q1_pc;
      end
      // The return lands in the first slot left free after the pop.
      if (push) begin
        if (eff_occ == 2'd0) begin
          q0_data <= mem_data;
          q0_pc   <= flight_pc;
        end else begin
          q1_data <= mem_data;
          q1_pc   <= flight_pc;
        end
      end
      count    <= eff_occ + {1'b0, push};
      inflight <= mem_read_en;
      if (mem_read_en) begin
        pc        <= pc + 1'b1;
        flight_pc <= pc;
      end
      if (incoming_halt) begin
        halt_seen <= 1'b1;
      end
      if (pop && (q0_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE)) begin
        halted <= 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetched_count <= '0;
      stall_count   <= '0;
    end else if (!halted) begin
      if (pop && (fetched_count != 32'hFFFF_FFFF)) begin
        fetched_count <= fetched_count + 32'd1;
      end
      if (inst_valid && !inst_ready && (stall_count != 32'hFFFF_FFFF)) begin
        stall_count <= stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized ready/jump traffic,
// checked against a reference model of the expected delivered instruction stream.
module tb_fetch_unit;

  localparam logic [4:0]  HALT_OP   = 5'h1F;
  localparam logic [15:0] HALT_WORD = 16'hF800;
  localparam logic [15:0] NOP_WORD  = 16'h0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read_en;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data = '0;
  logic [15:0] inst;
  logic [9:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        jump = 1'b0;
  logic [9:0]  jump_target = '0;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_count;
  logic [31:0] stall_count;
`endif

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .mem_read_en (mem_read_en),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .jump        (jump),
    .jump_target (jump_target),
    .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetched_count (fetched_count),
    .stall_count   (stall_count)
`endif
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:1023];

  always @(posedge clock) begin
    if (mem_read_en) mem_data <= mem[mem_addr];
  end

  int testsRun = 0;
  int testsFailed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic bit isHalt(input logic [15:0] w);
    return w[15:11] == HALT_OP;
  endfunction

  // How far ahead of the head a read may legally go: two words, but never past a HALT.
  function automatic int unsigned haltLimit(input int unsigned head);
    for (int k = 0; k < 2; k++) begin
      if (isHalt(mem[10'((head + k) % 1024)])) return k;
    end
    return 2;
  endfunction

  // Reference model: the expected stream is consecutive PCs from the last reset/jump until a HALT is accepted.
  int unsigned expPc;
  bit          modelHalted;
  bit          holdActive;
  logic [9:0]  holdPc;
  logic [15:0] holdInst;
  int          idleReady;
  int          cycleNo;
  int unsigned issuedCount;
  int unsigned maxAddr;
  int unsigned delivered[$];
  int          deliveredCycle[$];

  always @(negedge clock) begin
    cycleNo++;
    if (!reset) begin
      expPc = 0;
      modelHalted = 0;
      holdActive = 0;
      idleReady = 0;
    end else begin
      if (mem_read_en) begin
        issuedCount++;
        if (32'(mem_addr) > maxAddr) maxAddr = 32'(mem_addr);
      end
      if (modelHalted) begin
        checkOutput("haltedFlag", 32'(halted), 32'd1);
        checkOutput("validAfterHalt", 32'(inst_valid), 32'd0);
        checkOutput("readAfterHalt", 32'(mem_read_en), 32'd0);
      end else begin
        if (holdActive) begin
          checkOutput("holdValid", 32'(inst_valid), 32'd1);
          checkOutput("holdPc", 32'(inst_pc), 32'(holdPc));
          checkOutput("holdInst", 32'(inst), 32'(holdInst));
        end
        if (jump) begin
          checkOutput("readInJump", 32'(mem_read_en), 32'd0);
          expPc = 32'(jump_target);
          holdActive = 0;
          idleReady = 0;
        end else begin
          if (mem_read_en)
            checkOutput("issueWindow", 32'(((32'(mem_addr) - expPc) & 32'd1023) <= haltLimit(expPc)), 32'd1);
          if (inst_valid && inst_ready) begin
            checkOutput("deliverPc", 32'(inst_pc), expPc);
            checkOutput("deliverInst", 32'(inst), 32'(mem[10'(expPc)]));
            delivered.push_back(32'(inst_pc));
            deliveredCycle.push_back(cycleNo);
            if (isHalt(mem[10'(expPc)])) modelHalted = 1;
            expPc = (expPc + 1) % 1024;
            idleReady = 0;
          end else if (inst_ready) begin
            idleReady++;
            if (idleReady > 4) begin
              checkOutput("progress", 32'(idleReady), 32'd0);
              idleReady = 0;
            end
          end
          holdActive = inst_valid && !inst_ready;
          holdPc = inst_pc;
          holdInst = inst;
        end
      end
    end
  end

  task automatic applyStimulus(input logic rdy, input logic jmp, input logic [9:0] tgt);
    @(posedge clock);
    #1;
    inst_ready = rdy;
    jump = jmp;
    jump_target = tgt;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_readEn"}, 32'(mem_read_en), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_inst"}, 32'(inst), 32'd0);
    checkOutput({tag, "_instPc"}, 32'(inst_pc), 32'd0);
    checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd0);
    checkOutput({tag, "_halted"}, 32'(halted), 32'd0);
  endtask

  // Asserts reset between clock edges and checks the outputs clear at once.
  task automatic enterReset(input string tag);
    @(posedge clock);
    #3;
    reset = 1'b0;
    jump = 1'b0;
    #1;
    checkResetOutputs(tag);
    repeat (2) @(posedge clock);
    delivered.delete();
    deliveredCycle.delete();
  endtask

  task automatic releaseReset(input logic rdy, input logic jmp, input logic [9:0] tgt);
    @(posedge clock);
    #1;
    reset = 1'b1;
    inst_ready = rdy;
    jump = jmp;
    jump_target = tgt;
    issuedCount = 0;
    maxAddr = 0;
  endtask

  task automatic checkDelivered(input string tag, input int idx, input int unsigned expected);
    if (idx < delivered.size()) checkOutput(tag, delivered[idx], expected);
    else checkOutput(tag, 32'hFFFF_FFFF, expected);
  endtask

  task automatic fillLoadc();
    for (int i = 0; i < 1024; i++) mem[i] = {5'h02, 11'($urandom)};
  endtask

  task automatic fillRandom();
    logic [15:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = 16'($urandom);
      if (w[15:11] == HALT_OP) w[15] = 1'b0;
      if ($urandom_range(0, 59) == 0) w = HALT_WORD;
      mem[i] = w;
    end
  endtask

  task automatic runProgram(input int stallCycles);
    enterReset("progReset");
    for (int i = 0; i < 1024; i++) mem[i] = (i < 8) ? {5'h02, 11'($urandom)} : ((i < 10) ? NOP_WORD : HALT_WORD);
    releaseReset(1'b1, 1'b0, 10'd0);
    @(posedge clock);
    #1;
    checkOutput("latencyEdge1", 32'(inst_valid), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("latencyValid", 32'(inst_valid), 32'd1);
    checkOutput("latencyPc", 32'(inst_pc), 32'd0);
    if (stallCycles > 0) begin
      inst_ready = 1'b0;
      repeat (stallCycles - 1) applyStimulus(1'b0, 1'b0, 10'd0);
      applyStimulus(1'b1, 1'b0, 10'd0);
    end
    repeat (20) applyStimulus(1'b1, 1'b0, 10'd0);
    checkOutput("progHalted", 32'(halted), 32'd1);
    checkOutput("progCount", 32'(delivered.size()), 32'd11);
    for (int i = 0; i < 11; i++) checkDelivered("progPc", i, i);
    checkOutput("progMaxAddr", maxAddr, 32'd10);
    if (stallCycles == 0 && deliveredCycle.size() == 11)
      checkOutput("progThroughput", 32'(deliveredCycle[10] - deliveredCycle[0]), 32'd10);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perfFetched", fetched_count, 32'd11);
    checkOutput("perfStall", stall_count, 32'(stallCycles));
`endif
  endtask

  task automatic runStall();
    enterReset("stallReset");
    fillLoadc();
    releaseReset(1'b0, 1'b0, 10'd0);
    for (int k = 0; k < 10 && !inst_valid; k++) applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("stallFirstValid", 32'(inst_valid), 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b0, 10'd0);
    checkOutput("stallHeadPc", 32'(inst_pc), 32'd0);
    checkOutput("stallNoneOut", 32'(delivered.size()), 32'd0);
    checkOutput("stallReads", 32'(issuedCount <= 2), 32'd1);
    repeat (6) applyStimulus(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < 3; i++) checkDelivered("stallOrder", i, i);
  endtask

  task automatic runJump();
    enterReset("jumpReset");
    fillLoadc();
    releaseReset(1'b1, 1'b0, 10'd0);
    for (int k = 0; k < 30 && delivered.size() < 3; k++) applyStimulus(1'b1, 1'b0, 10'd0);
    inst_ready = 1'b0;
    jump = 1'b1;
    jump_target = 10'h020;
    repeat (8) applyStimulus(1'b1, 1'b0, 10'd0);
    checkDelivered("jumpFirst", 3, 32'h20);
    checkDelivered("jumpSecond", 4, 32'h21);
  endtask

  task automatic runWrap();
    enterReset("wrapReset");
    fillLoadc();
    releaseReset(1'b1, 1'b1, 10'h3FF);
    repeat (8) applyStimulus(1'b1, 1'b0, 10'd0);
    checkDelivered("wrapTop", 0, 32'h3FF);
    checkDelivered("wrapZero", 1, 32'h000);
    checkDelivered("wrapOne", 2, 32'h001);
  endtask

  task automatic runAsyncReset();
    enterReset("asyncPre");
    fillLoadc();
    releaseReset(1'b1, 1'b0, 10'd0);
    repeat (7) applyStimulus(1'b1, 1'b0, 10'd0);
    enterReset("asyncMid");
    releaseReset(1'b1, 1'b0, 10'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    checkOutput("restartValid", 32'(inst_valid), 32'd1);
    checkOutput("restartPc", 32'(inst_pc), 32'd0);
    checkOutput("restartHalted", 32'(halted), 32'd0);
  endtask

  task automatic runRandom();
    for (int run = 0; run < 6; run++) begin
      enterReset("randReset");
      fillRandom();
      releaseReset(1'b1, 1'b0, 10'd0);
      for (int c = 0; c < 400; c++)
        applyStimulus($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 4, 10'($urandom));
    end
  endtask

  initial begin
    fillLoadc();
    repeat (2) @(posedge clock);
    #1;
    checkResetOutputs("powerOn");
    runProgram(0);
`ifdef FETCH_PERF_CNT_EN
    runProgram(3);
`endif
    runStall();
    runJump();
    runWrap();
    runAsyncReset();
    runRandom();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
